ecomp_sat_adder_pipe: RTL and testbench

- Pipelined, parametrised error-compensation adder for the low-voltage MAC datapath.
- Adds a signed or unsigned error-correction term to a MAC partial sum.
- Result either saturates or wraps (set by parameter); every result carries a per-result overflow flag.
- Sits between the error-estimation unit and the accumulator writeback; valid/ready on both sides; counts saturation events for voltage-scaling telemetry.

---
 rtl/ecomp_sat_adder_pipe.sv | 138 +++++++++++++
 tb/tb_ecomp_sat_adder_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecomp_sat_adder_pipe.sv
// Pipelined error-compensation adder: partial sum + error term with overflow flag,
// optional saturation, and a saturation-event counter. One global advance enable.
module ecomp_sat_adder_pipe #(
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned PSUM_W   = 24,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned PIPE     = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ERR_W-1:0]  error_sum,
  input  logic [PSUM_W-1:0] partial_sum_in,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] sum,
  output logic              out_last,
  output logic              ovf,
  output logic [CNT_W-1:0]  sat_cnt,
  input  logic              clr_cnt
);

  localparam int unsigned ExtW = PSUM_W + 1;

  if (ERR_W > PSUM_W) begin : g_chk_err_w
    $error("ecomp_sat_adder_pipe: ERR_W must not exceed PSUM_W");
  end
  if (PIPE != 1 && PIPE != 2) begin : g_chk_pipe
    $error("ecomp_sat_adder_pipe: PIPE must be 1 or 2");
  end

  logic              adv;
  logic              out_valid_q, out_last_q, ovf_q;
  logic [PSUM_W-1:0] sum_q;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  logic              psum_sign, err_sign;
  logic [ExtW-1:0]   psum_ext, err_ext;
  logic [ExtW-1:0]   op_a, op_b, raw;
  logic              op_valid, op_last;
  logic              ovf_raw, ovf_d, last_d;
  logic [PSUM_W-1:0] sat_val, res_d;

  // Every stage shifts together, bubbles included, whenever the output slot frees up.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  assign psum_sign = (SIGNED != 0) && partial_sum_in[PSUM_W-1];
  assign err_sign  = (SIGNED != 0) && error_sum[ERR_W-1];
  assign psum_ext  = {psum_sign, partial_sum_in};
  assign err_ext   = {{(ExtW-ERR_W){err_sign}}, error_sum};

  if (PIPE == 2) begin : g_pipe2
    logic            s1_valid_q, s1_last_q;
    logic [ExtW-1:0] s1_a_q, s1_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else if (adv) begin
        s1_valid_q <= in_valid;
        s1_last_q  <= in_last;
        s1_a_q     <= psum_ext;
        s1_b_q     <= err_ext;
      end
    end

    assign op_valid = s1_valid_q;
    assign op_last  = s1_last_q;
    assign op_a     = s1_a_q;
    assign op_b     = s1_b_q;
  end else begin : g_pipe1
    assign op_valid = in_valid;
    assign op_last  = in_last;
    assign op_a     = psum_ext;
    assign op_b     = err_ext;
  end

  always_comb begin
    raw = op_a + op_b;
    if (SIGNED != 0) begin
      // Extension bit disagreeing with the result MSB means the true value left the range.
      ovf_raw = raw[PSUM_W] ^ raw[PSUM_W-1];
      sat_val = raw[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    end else begin
      ovf_raw = raw[PSUM_W];
      sat_val = '1;
    end
    res_d  = ((SATURATE != 0) && ovf_raw) ? sat_val : raw[PSUM_W-1:0];
    ovf_d  = op_valid && ovf_raw;
    last_d = op_valid && op_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
    end else if (adv) begin
      out_valid_q <= op_valid;
      out_last_q  <= last_d;
      ovf_q       <= ovf_d;
      sum_q       <= res_d;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_cnt) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready && ovf_q && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign sum       = sum_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_ecomp_sat_adder_pipe.sv
// Directed bench for ecomp_sat_adder_pipe: five parameter variants share one stimulus stream.
module tb_ecomp_sat_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, out_ready, clr_cnt;
  logic [15:0] error_sum;
  logic [23:0] partial_sum_in;

  logic        d_in_ready, d_out_valid, d_out_last, d_ovf;
  logic [23:0] d_sum;
  logic [15:0] d_sat_cnt;
  logic        w_in_ready, w_out_valid, w_out_last, w_ovf;
  logic [23:0] w_sum;
  logic [15:0] w_sat_cnt;
  logic        u_in_ready, u_out_valid, u_out_last, u_ovf;
  logic [23:0] u_sum;
  logic [15:0] u_sat_cnt;
  logic        c_in_ready, c_out_valid, c_out_last, c_ovf;
  logic [23:0] c_sum;
  logic [1:0]  c_sat_cnt;
  logic        p_in_ready, p_out_valid, p_out_last, p_ovf;
  logic [23:0] p_sum;
  logic [15:0] p_sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecomp_sat_adder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .error_sum(error_sum), .partial_sum_in(partial_sum_in), .in_last(in_last),
    .out_valid(d_out_valid), .out_ready(out_ready), .sum(d_sum), .out_last(d_out_last),
    .ovf(d_ovf), .sat_cnt(d_sat_cnt), .clr_cnt(clr_cnt)
  );

  ecomp_sat_adder_pipe #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .error_sum(error_sum), .partial_sum_in(partial_sum_in), .in_last(in_last),
    .out_valid(w_out_valid), .out_ready(out_ready), .sum(w_sum), .out_last(w_out_last),
    .ovf(w_ovf), .sat_cnt(w_sat_cnt), .clr_cnt(clr_cnt)
  );

  ecomp_sat_adder_pipe #(.SIGNED(0)) dut_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .error_sum(error_sum), .partial_sum_in(partial_sum_in), .in_last(in_last),
    .out_valid(u_out_valid), .out_ready(out_ready), .sum(u_sum), .out_last(u_out_last),
    .ovf(u_ovf), .sat_cnt(u_sat_cnt), .clr_cnt(clr_cnt)
  );

  ecomp_sat_adder_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .error_sum(error_sum), .partial_sum_in(partial_sum_in), .in_last(in_last),
    .out_valid(c_out_valid), .out_ready(out_ready), .sum(c_sum), .out_last(c_out_last),
    .ovf(c_ovf), .sat_cnt(c_sat_cnt), .clr_cnt(clr_cnt)
  );

  ecomp_sat_adder_pipe #(.PIPE(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready),
    .error_sum(error_sum), .partial_sum_in(partial_sum_in), .in_last(in_last),
    .out_valid(p_out_valid), .out_ready(out_ready), .sum(p_sum), .out_last(p_out_last),
    .ovf(p_ovf), .sat_cnt(p_sat_cnt), .clr_cnt(clr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle input pulse; returns just after the capturing edge.
  task automatic drive1(input logic [23:0] ps, input logic [15:0] es);
    in_valid       = 1'b1;
    partial_sum_in = ps;
    error_sum      = es;
    in_last        = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    #12 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; partial_sum_in = 24'h7FFFF0; error_sum = 16'h0020; in_last = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (d_sum !== 24'h0 || d_out_valid !== 1'b0 || d_ovf !== 1'b0 || d_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h valid=%b ovf=%b last=%b, expected all zero",
               d_sum, d_out_valid, d_ovf, d_out_last);
    end
    checks++;
    if (d_sat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat_cnt: got %0d expected 0", d_sat_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
               d_in_ready, d_out_valid);
    end
  endtask

  task automatic test_nominal();
    int n;
    out_ready = 1'b1;
    drive1(24'h000100, 16'h0010);
    checks++;
    if (p_out_valid !== 1'b1 || p_sum !== 24'h000110) begin
      errors++;
      $display("FAIL pipe1_latency: got valid=%b sum=%h expected 1/000110", p_out_valid, p_sum);
    end
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pipe2_early: got out_valid=%b expected 0", d_out_valid);
    end
    tick();
    checks++;
    if (d_out_valid !== 1'b1 || d_sum !== 24'h000110 || d_ovf !== 1'b0) begin
      errors++;
      $display("FAIL nominal_sum: got valid=%b sum=%h ovf=%b expected 1/000110/0",
               d_out_valid, d_sum, d_ovf);
    end
    tick();
    checks++;
    if (d_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nominal_single: got out_valid=%b expected 0", d_out_valid);
    end
    n = 0;
    for (int c = 0; c < 11; c++) begin
      in_valid       = (c < 8);
      partial_sum_in = 24'h000100 + 24'(c);
      error_sum      = 16'h0010;
      in_last        = 1'b0;
      tick();
      if (d_out_valid) begin
        checks++;
        if (d_sum !== 24'h000110 + 24'(n) || c != n + 1) begin
          errors++;
          $display("FAIL b2b_result: got sum=%h at cycle %0d expected %h at cycle %0d",
                   d_sum, c, 24'h000110 + 24'(n), n + 1);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 8", n);
    end
  endtask

  task automatic test_signed_sat();
    out_ready = 1'b1;
    pulse_clr();
    drive1(24'h7FFFF0, 16'h0020);
    checks++;
    if (p_sum !== 24'h7FFFFF || p_ovf !== 1'b1) begin
      errors++;
      $display("FAIL pipe1_pos_sat: got sum=%h ovf=%b expected 7fffff/1", p_sum, p_ovf);
    end
    tick();
    checks++;
    if (d_sum !== 24'h7FFFFF || d_ovf !== 1'b1) begin
      errors++;
      $display("FAIL pos_sat: got sum=%h ovf=%b expected 7fffff/1", d_sum, d_ovf);
    end
    checks++;
    if (w_sum !== 24'h800010 || w_ovf !== 1'b1) begin
      errors++;
      $display("FAIL pos_wrap: got sum=%h ovf=%b expected 800010/1", w_sum, w_ovf);
    end
    tick();
    checks++;
    if (d_sat_cnt !== 16'd1) begin
      errors++;
      $display("FAIL sat_cnt_1: got %0d expected 1", d_sat_cnt);
    end
    drive1(24'h800005, 16'hFFF0);
    tick();
    checks++;
    if (d_sum !== 24'h800000 || d_ovf !== 1'b1) begin
      errors++;
      $display("FAIL neg_sat: got sum=%h ovf=%b expected 800000/1", d_sum, d_ovf);
    end
    checks++;
    if (w_sum !== 24'h7FFFF5 || w_ovf !== 1'b1) begin
      errors++;
      $display("FAIL neg_wrap: got sum=%h ovf=%b expected 7ffff5/1", w_sum, w_ovf);
    end
    tick();
    checks++;
    if (d_sat_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sat_cnt_2: got %0d expected 2", d_sat_cnt);
    end
    drive1(24'h7FFFEF, 16'h0010);
    tick();
    checks++;
    if (d_sum !== 24'h7FFFFF || d_ovf !== 1'b0) begin
      errors++;
      $display("FAIL exact_max: got sum=%h ovf=%b expected 7fffff/0", d_sum, d_ovf);
    end
    drive1(24'h800010, 16'hFFF0);
    tick();
    checks++;
    if (d_sum !== 24'h800000 || d_ovf !== 1'b0) begin
      errors++;
      $display("FAIL exact_min: got sum=%h ovf=%b expected 800000/0", d_sum, d_ovf);
    end
    tick();
    checks++;
    if (d_sat_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sat_cnt_no_ovf: got %0d expected 2", d_sat_cnt);
    end
  endtask

  task automatic test_unsigned();
    out_ready = 1'b1;
    drive1(24'hFFFFF0, 16'h0020);
    tick();
    checks++;
    if (u_sum !== 24'hFFFFFF || u_ovf !== 1'b1) begin
      errors++;
      $display("FAIL uns_sat: got sum=%h ovf=%b expected ffffff/1", u_sum, u_ovf);
    end
    drive1(24'h000001, 16'hFFFF);
    tick();
    checks++;
    if (u_sum !== 24'h010000 || u_ovf !== 1'b0) begin
      errors++;
      $display("FAIL uns_no_ovf: got sum=%h ovf=%b expected 010000/0", u_sum, u_ovf);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int  n, idx, stall;
    bit  started, acc;
    n = 0; idx = 0; stall = 0; started = 0;
    for (int c = 0; c < 30; c++) begin
      if (d_out_valid && !started) begin
        started = 1;
        stall   = 3;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_sum !== 24'd1) begin
          errors++;
          $display("FAIL stall_hold: got in_ready=%b valid=%b sum=%h expected 0/1/000001",
                   d_in_ready, d_out_valid, d_sum);
        end
        stall--;
      end
      if (d_out_valid && out_ready) begin
        checks++;
        if (d_sum !== 24'(n + 1) || d_out_last !== (n == 3)) begin
          errors++;
          $display("FAIL bp_order: got sum=%h last=%b expected %h/%b",
                   d_sum, d_out_last, 24'(n + 1), (n == 3));
        end
        n++;
      end
      in_valid       = (idx < 4);
      partial_sum_in = 24'(idx + 1);
      error_sum      = 16'h0000;
      in_last        = (idx == 3);
      acc            = in_valid && d_in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results expected 4", n);
    end
    // A stalled overflowing result is counted on its transfer only.
    pulse_clr();
    out_ready = 1'b0;
    drive1(24'h7FFFF0, 16'h0020);
    tick(); tick(); tick();
    checks++;
    if (d_sat_cnt !== 16'd0 || d_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_cnt_hold: got cnt=%0d valid=%b expected 0/1", d_sat_cnt, d_out_valid);
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (d_sat_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_cnt_once: got %0d expected 1", d_sat_cnt);
    end
  endtask

  task automatic test_counter_edges();
    out_ready = 1'b1;
    drive1(24'h7FFFF0, 16'h0020);
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (d_sat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: got %0d expected 0", d_sat_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      drive1(24'h7FFFF0, 16'h0020);
      tick();
      tick();
    end
    checks++;
    if (c_sat_cnt !== 2'd3) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d expected 3", c_sat_cnt);
    end
    checks++;
    if (d_sat_cnt !== 16'd5) begin
      errors++;
      $display("FAIL cnt_five: got %0d expected 5", d_sat_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; partial_sum_in = 24'd5; error_sum = 16'd0; in_last = 1'b0;
    tick();
    partial_sum_in = 24'd6;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (d_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d valid cycles expected 0", seen);
    end
    drive1(24'h000010, 16'h0001);
    tick();
    checks++;
    if (d_out_valid !== 1'b1 || d_sum !== 24'h000011) begin
      errors++;
      $display("FAIL post_reset: got valid=%b sum=%h expected 1/000011", d_out_valid, d_sum);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    error_sum = '0; partial_sum_in = '0;
    test_reset();
    test_nominal();
    test_signed_sat();
    test_unsigned();
    test_backpressure();
    test_counter_edges();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
